// File: rtl/pipeline_stall_controller.sv
// -----------------------------------------------------------------------------
// pipeline_stall_controller
//
// Central hazard controller for a classic 5-stage in-order pipeline. It turns
// three hazard sources into per-register stall/flush/bubble controls:
//   * data-memory wait  (freeze)   : dmem_access=1 while dmem_ready=0
//   * taken branch      (flush)    : squash the two wrong-path instructions
//   * load-use hazard   (stall)    : hold PC and IF/ID, bubble into ID/EX
// Priority is freeze > branch > load-use. Control outputs are combinational
// from the current state and inputs; state, counters and the timeout flag are
// registered.
//
// Ports
//   clk             in   rising-edge clock
//   reset_n         in   asynchronous active-low reset
//   load_use_hazard in   load-use detected in ID
//   branch_taken    in   branch resolved taken in EX
//   dmem_access     in   MEM-stage instruction is a load/store
//   dmem_ready      in   data memory completes the access this cycle
//   cnt_clr         in   synchronous clear of stall_count
//   pc_stall        out  hold PC
//   IF_ID_stall     out  hold IF/ID
//   IF_ID_flush     out  zero IF/ID
//   ID_EX_flush     out  bubble into ID/EX
//   ID_EX_stall     out  hold ID/EX
//   EX_MEM_stall    out  hold EX/MEM
//   MEM_WB_bubble   out  write a bubble into MEM/WB
//   state[1:0]      out  RUN=00, MEM_WAIT=01, FLUSH=10
//   stall_count     out  saturating count of cycles with pc_stall=1
//   mem_timeout     out  sticky: memory wait exceeded 255 cycles
// -----------------------------------------------------------------------------
module pipeline_stall_controller (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load_use_hazard,
    input  logic        branch_taken,
    input  logic        dmem_access,
    input  logic        dmem_ready,
    input  logic        cnt_clr,
    output logic        pc_stall,
    output logic        IF_ID_stall,
    output logic        IF_ID_flush,
    output logic        ID_EX_flush,
    output logic        ID_EX_stall,
    output logic        EX_MEM_stall,
    output logic        MEM_WB_bubble,
    output logic [1:0]  state,
    output logic [15:0] stall_count,
    output logic        mem_timeout
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_MEM_WAIT = 2'b01,
        ST_FLUSH    = 2'b10
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [7:0]  r_wait_cnt;
    logic [15:0] r_stall_count;
    logic        r_mem_timeout;
    logic        w_freeze;

    assign w_freeze = dmem_access & ~dmem_ready;

    // Decode. MEM_WAIT with dmem_ready=1 falls through to the same branch /
    // load-use handling as RUN, so a branch captured in the frozen EX/MEM
    // register is acted on in the release cycle. Only FLUSH suppresses
    // load-use, since the instruction in ID is on the wrong path there.
    always_comb begin
        pc_stall      = 1'b0;
        IF_ID_stall   = 1'b0;
        IF_ID_flush   = 1'b0;
        ID_EX_flush   = 1'b0;
        ID_EX_stall   = 1'b0;
        EX_MEM_stall  = 1'b0;
        MEM_WB_bubble = 1'b0;
        w_state_next  = ST_RUN;

        if (w_freeze) begin
            pc_stall      = 1'b1;
            IF_ID_stall   = 1'b1;
            ID_EX_stall   = 1'b1;
            EX_MEM_stall  = 1'b1;
            MEM_WB_bubble = 1'b1;
            w_state_next  = ST_MEM_WAIT;
        end else if (branch_taken) begin
            IF_ID_flush  = 1'b1;
            ID_EX_flush  = 1'b1;
            w_state_next = ST_FLUSH;
        end else if (load_use_hazard && (r_state != ST_FLUSH)) begin
            pc_stall     = 1'b1;
            IF_ID_stall  = 1'b1;
            ID_EX_flush  = 1'b1;
            w_state_next = ST_RUN;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_RUN;
            r_wait_cnt    <= 8'd0;
            r_stall_count <= 16'd0;
            r_mem_timeout <= 1'b0;
        end else begin
            r_state <= w_state_next;

            // Wait length is measured only while already parked in MEM_WAIT.
            if (!w_freeze) begin
                r_wait_cnt <= 8'd0;
            end else if ((r_state == ST_MEM_WAIT) && (r_wait_cnt != 8'hFF)) begin
                r_wait_cnt <= r_wait_cnt + 8'd1;
            end

            // Sticky until reset; the FSM keeps waiting regardless.
            if (w_freeze && (r_state == ST_MEM_WAIT) && (r_wait_cnt == 8'hFF)) begin
                r_mem_timeout <= 1'b1;
            end

            if (cnt_clr) begin
                r_stall_count <= 16'd0;
            end else if (pc_stall && (r_stall_count != 16'hFFFF)) begin
                r_stall_count <= r_stall_count + 16'd1;
            end
        end
    end

    assign state       = r_state;
    assign stall_count = r_stall_count;
    assign mem_timeout = r_mem_timeout;

endmodule
